maze_grid_ctrl: RTL and testbench

- Owns the maze-cell value memory: ROWS x COLS cells of 2-bit value codes feeding the per-pixel block colour formatter.
- Arbitrates the single memory port between the VGA pixel read path (active display) and a queued cell-update write path (blanking only).
- Sequences a full-grid clear after reset or on command.
- Sits between the VGA driver / radio-update logic and the colour formatter.

---
 rtl/maze_grid_ctrl.sv | 142 ++++++++++++++
 tb/tb_maze_grid_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_grid_ctrl.sv
// Maze cell value store: a single-port ROWS x COLS grid of 2-bit codes. The VGA read
// path uses the port during active video; queued cell updates and the clear sweep use it during blanking.
module maze_grid_ctrl #(
    parameter int COLS       = 16,
    parameter int ROWS       = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [9:0] PIXEL_X,
    input  logic [9:0] PIXEL_Y,
    input  logic       CLEAR,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic [3:0] WR_ROW,
    input  logic [3:0] WR_COL,
    input  logic [1:0] WR_VALUE,
    output logic [1:0] VALUE_OUT,
    output logic [9:0] X_OUT,
    output logic [9:0] Y_OUT,
    output logic       BUSY,
    output logic       WR_DROP
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] value;
    } upd_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    upd_t             fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       mem [CELLS];

    logic             active, blank;
    logic [4:0]       pix_row;
    logic [3:0]       pix_col;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    upd_t             head;
    logic             head_ok, full, empty, push, pop, clr_wr;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [1:0]       mem_wdata;

    assign active  = (PIXEL_X < 10'd640) && (PIXEL_Y < 10'd480);
    assign blank   = !active;
    assign pix_row = PIXEL_Y[9:5];
    assign pix_col = PIXEL_X[8:5];
    assign rd_en   = active && !PIXEL_X[9] && (int'(pix_row) < ROWS) && (state == ST_RUN);
    assign rd_idx  = IDX_W'(int'(pix_row) * COLS + int'(pix_col));

    assign head    = fifo[rd_ptr];
    assign head_ok = (int'(head.row) < ROWS) && (int'(head.col) < COLS);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);

    assign WR_READY = (state == ST_RUN) && !full;
    assign BUSY     = (state == ST_CLEAR);

    // A CLEAR in the same cycle flushes the queue, so a coincident handshake is simply lost.
    assign push    = WR_VALID && WR_READY && !CLEAR && !RESET;
    assign pop     = (state == ST_RUN) && !RESET && !CLEAR && blank && !empty;
    assign WR_DROP = pop && !head_ok;
    assign clr_wr  = (state == ST_CLEAR) && !RESET && !CLEAR && blank;

    // Writes only happen in blanking and reads only matter in active video, so the port never collides.
    always_comb begin
        mem_we    = clr_wr || (pop && head_ok);
        mem_waddr = IDX_W'(int'(head.row) * COLS + int'(head.col));
        mem_wdata = head.value;
        if (clr_wr) begin
            mem_waddr = clr_idx;
            mem_wdata = 2'b00;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge CLOCK) begin
        if (push)
            fifo[wr_ptr] <= '{row: WR_ROW, col: WR_COL, value: WR_VALUE};
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            VALUE_OUT <= 2'b00;
            X_OUT     <= '0;
            Y_OUT     <= '0;
        end else begin
            VALUE_OUT <= rd_en ? mem[rd_idx] : 2'b00;
            X_OUT     <= PIXEL_X;
            Y_OUT     <= PIXEL_Y;
            case (state)
                ST_CLEAR: begin
                    if (CLEAR) begin
                        clr_idx <= '0;
                    end else if (blank) begin
                        if (clr_idx == LAST_IDX) begin
                            state   <= ST_RUN;
                            clr_idx <= '0;
                        end else begin
                            clr_idx <= clr_idx + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (CLEAR) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                        rd_ptr  <= '0;
                        wr_ptr  <= '0;
                        count   <= '0;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + 1'b1;
                        if (pop)  rd_ptr <= rd_ptr + 1'b1;
                        count <= count + CNT_W'(push) - CNT_W'(pop);
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_grid_ctrl.sv
// Scoreboard bench for maze_grid_ctrl: the driver pushes expected outputs from a
// grid/queue reference model; a negedge monitor pops and compares them.
module tb_maze_grid_ctrl;
    localparam int COLS  = 16;
    localparam int ROWS  = 15;
    localparam int DEPTH = 4;
    localparam int CELLS = ROWS * COLS;

    logic       clk = 1'b0;
    logic       RESET = 1'b1, CLEAR = 1'b0, WR_VALID = 1'b0;
    logic [9:0] PIXEL_X = 10'd700, PIXEL_Y = 10'd0;
    logic [3:0] WR_ROW = '0, WR_COL = '0;
    logic [1:0] WR_VALUE = '0;
    logic       WR_READY, BUSY, WR_DROP;
    logic [1:0] VALUE_OUT;
    logic [9:0] X_OUT, Y_OUT;

    maze_grid_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK(clk), .RESET(RESET), .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y),
        .CLEAR(CLEAR), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_ROW(WR_ROW), .WR_COL(WR_COL), .WR_VALUE(WR_VALUE),
        .VALUE_OUT(VALUE_OUT), .X_OUT(X_OUT), .Y_OUT(Y_OUT),
        .BUSY(BUSY), .WR_DROP(WR_DROP)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, x, y, busy, ready, drop;
    } exp_t;

    typedef struct {
        int r, c, v;
    } upd_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: grid contents, pending-update queue, sweep progress, output regs.
    int   m_grid [ROWS][COLS];
    upd_t m_q[$];
    bit   m_known = 0;
    bit   m_busy = 1;
    int   m_clr = 0;
    int   m_vout = 0, m_xo = 0, m_yo = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit clr, input bit wv, input int wr, input int wc,
                         input int wval, input int px, input int py);
        bit   act, can_push;
        exp_t e;
        upd_t u;
        @(negedge clk);
        RESET = rst; CLEAR = clr; WR_VALID = wv;
        WR_ROW = 4'(wr); WR_COL = 4'(wc); WR_VALUE = 2'(wval);
        PIXEL_X = 10'(px); PIXEL_Y = 10'(py);
        act = (px < 640) && (py < 480);
        if (m_known) begin
            e.v = m_vout; e.x = m_xo; e.y = m_yo; e.busy = int'(m_busy);
            e.ready = int'(!m_busy && m_q.size() < DEPTH);
            e.drop = int'(!rst && !m_busy && !clr && !act && m_q.size() > 0 &&
                          (m_q[0].r >= ROWS || m_q[0].c >= COLS));
            exp_q.push_back(e);
        end
        if (rst) begin
            m_known = 1; m_busy = 1; m_clr = 0; m_q.delete();
            m_vout = 0; m_xo = 0; m_yo = 0;
        end else begin
            m_vout = (act && px < 512 && py / 32 < ROWS && !m_busy) ? m_grid[py / 32][px / 32] : 0;
            m_xo = px; m_yo = py;
            if (m_busy) begin
                if (clr) m_clr = 0;
                else if (!act) begin
                    m_grid[m_clr / COLS][m_clr % COLS] = 0;
                    if (m_clr == CELLS - 1) begin m_busy = 0; m_clr = 0; end
                    else m_clr++;
                end
            end else if (clr) begin
                m_busy = 1; m_clr = 0; m_q.delete();
            end else begin
                can_push = wv && (m_q.size() < DEPTH);
                if (!act && m_q.size() > 0) begin
                    u = m_q.pop_front();
                    if (u.r < ROWS && u.c < COLS) m_grid[u.r][u.c] = u.v;
                end
                if (can_push) m_q.push_back('{r: wr, c: wc, v: wval});
            end
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 700, 100);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 700, 100);
            if (BUSY) n++;
            else break;
        end
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        cycle(0, 0, 0, 0, 0, 0, c * 32 + 7, r * 32 + 9);
        cycle(0, 0, 0, 0, 0, 0, 700, 100);
        v = int'(VALUE_OUT);
    endtask

    task automatic scan_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cycle(0, 0, 0, 0, 0, 0, c * 32 + 7, r * 32 + 9);
        idle(1);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        #1;
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("value_out", int'(VALUE_OUT), mon_e.v);
            chk("x_out", int'(X_OUT), mon_e.x);
            chk("y_out", int'(Y_OUT), mon_e.y);
            chk("busy", int'(BUSY), mon_e.busy);
            chk("wr_ready", int'(WR_READY), mon_e.ready);
            chk("wr_drop", int'(WR_DROP), mon_e.drop);
        end
    end

    initial begin
        int n, v, acc, drops;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_grid[r][c] = 0;

        // Reset, first sweep, all-zero grid
        cycle(1, 0, 0, 0, 0, 0, 700, 100);
        cycle(1, 0, 0, 0, 0, 0, 700, 100);
        chk("reset_busy", int'(BUSY), 1);
        chk("reset_ready", int'(WR_READY), 0);
        chk("reset_value", int'(VALUE_OUT), 0);
        count_busy(n);
        chk("sweep_len_reset", n, 240);
        chk("ready_after_sweep", int'(WR_READY), 1);
        scan_all();

        // Single update then readback with aligned coordinates
        cycle(0, 0, 1, 3, 5, 2, 700, 100);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 170, 100);
        cycle(0, 0, 0, 0, 0, 0, 700, 100);
        chk("t2_value", int'(VALUE_OUT), 2);
        chk("t2_x", int'(X_OUT), 170);
        chk("t2_y", int'(Y_OUT), 100);

        // Back-to-back pushes during active video fill the queue
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, i, 8, (i % 3) + 1, 10, 10);
            if (WR_READY) acc++;
        end
        chk("t3_accepted", acc, 4);
        chk("t3_ready_full", int'(WR_READY), 0);
        idle(4);
        idle(1);
        chk("t3_ready_drained", int'(WR_READY), 1);
        read_cell(0, 8, v);
        chk("t3_cell0", v, 1);
        read_cell(3, 8, v);
        chk("t3_cell3", v, 1);
        read_cell(4, 8, v);
        chk("t3_cell4_rejected", v, 0);

        // Out-of-range row is dropped
        cycle(0, 0, 1, 15, 0, 3, 10, 10);
        cycle(0, 0, 1, 2, 2, 1, 10, 10);
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 700, 100);
            if (WR_DROP) drops++;
        end
        chk("t4_drops", drops, 1);
        read_cell(2, 2, v);
        chk("t4_cell22", v, 1);
        cycle(0, 0, 0, 0, 0, 0, 7, 481);
        cycle(0, 0, 0, 0, 0, 0, 700, 100);
        chk("t4_row15", int'(VALUE_OUT), 0);

        // CLEAR flushes the queued updates
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 5 + i, 5 + i, 3, 10, 10);
        cycle(0, 1, 0, 0, 0, 0, 10, 10);
        count_busy(n);
        chk("sweep_len_clear", n, 240);
        read_cell(5, 5, v);
        chk("t5_flushed", v, 0);
        read_cell(3, 5, v);
        chk("t5_cleared", v, 0);
        scan_all();

        // Reset mid-sweep restarts from zero
        cycle(0, 1, 0, 0, 0, 0, 700, 100);
        idle(100);
        cycle(1, 0, 0, 0, 0, 0, 700, 100);
        count_busy(n);
        chk("sweep_len_midreset", n, 240);

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            int k, px, py;
            bit rst, clr, wv;
            k = $urandom_range(0, 9);
            if (k < 5) begin px = $urandom_range(0, 511); py = $urandom_range(0, 479); end
            else if (k < 6) begin px = $urandom_range(512, 639); py = $urandom_range(0, 479); end
            else if (k < 8) begin px = $urandom_range(640, 1023); py = $urandom_range(0, 1023); end
            else begin px = $urandom_range(0, 1023); py = $urandom_range(480, 1023); end
            rst = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 399) == 0);
            wv  = ($urandom_range(0, 9) < 4);
            cycle(rst, clr, wv, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3), px, py);
        end
        count_busy(n);
        scan_all();

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
